// File: rtl/cpu_pipe_pkg.sv
// Shared types for elastic CPU pipeline stage registers.
// Occupancy helper lets control logic reason in entries rather than encodings.
package cpu_pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } pipe_state_t;

  localparam logic [1:0] PIPE_DEPTH = 2'd2;

  function automatic logic [1:0] pipe_occupancy(input pipe_state_t s);
    case (s)
      EMPTY:   return 2'd0;
      ONE:     return 2'd1;
      FULL:    return 2'd2;
      default: return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/flopenr.sv
// Enabled register with synchronous active-high clear.
// One-cycle latency; holds its value whenever en is low.
module flopenr #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;

  always_comb begin
    q_d = q_q;
    if (en) begin
      q_d = d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/pipe_skid_reg.sv
// Two-entry skid pipeline register; one-cycle latency, 1 word/cycle sustained.
// Backpressure: in_ready is registered and drops only once the skid entry is occupied.
module pipe_skid_reg
  import cpu_pipe_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  pipe_state_t      state_q, state_d;
  logic             out_valid_q, out_valid_d;
  logic             in_ready_q, in_ready_d;
  logic             main_en, skid_en;
  logic [WIDTH-1:0] main_d, main_q, skid_q;
  logic             in_xfer, out_xfer;
  logic [1:0]       occ_d;

  assign in_xfer  = in_valid && in_ready_q;
  assign out_xfer = out_valid_q && out_ready;

  always_comb begin
    state_d = state_q;
    main_en = 1'b0;
    main_d  = in_data;
    skid_en = 1'b0;
    if (flush) begin
      // Squash drops any incoming word; main keeps its stale contents.
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (in_xfer) begin
            state_d = ONE;
            main_en = 1'b1;
          end
        end
        ONE: begin
          if (in_xfer && out_xfer) begin
            main_en = 1'b1;
          end else if (in_xfer) begin
            state_d = FULL;
            skid_en = 1'b1;
          end else if (out_xfer) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          if (out_xfer) begin
            state_d = ONE;
            main_en = 1'b1;
            main_d  = skid_q;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
    occ_d       = pipe_occupancy(state_d);
    out_valid_d = (occ_d != 2'd0);
    in_ready_d  = (occ_d != PIPE_DEPTH);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= EMPTY;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
    end
  end

  flopenr #(.WIDTH(WIDTH)) u_main (
    .clk   (clk),
    .reset (reset),
    .en    (main_en),
    .d     (main_d),
    .q     (main_q)
  );

  flopenr #(.WIDTH(WIDTH)) u_skid (
    .clk   (clk),
    .reset (reset),
    .en    (skid_en),
    .d     (in_data),
    .q     (skid_q)
  );

  assign out_data  = main_q;
  assign out_valid = out_valid_q;
  assign in_ready  = in_ready_q;

endmodule
